// File: rtl/mem_responder.sv
// mem_responder: single-port 16-bit word memory behind a fixed-latency
// request/response handshake. Each accepted read or write spends
// WAIT_CYCLES cycles in WAIT, one cycle in ACCESS, then pulses done.
module mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        MC,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       WRdata,
  output logic [15:0]       Mdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_e;

  // The counter holds the number of WAIT cycles still to run after the
  // current one, so it starts one below WAIT_CYCLES.
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  logic [15:0]       mem [2**ADDR_W];

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic [15:0]       mdata_q, mdata_d;
  logic              err_q, err_d;

  // State, latched request and read-data registers; memory is not reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 16'h0000;
      wr_q    <= 1'b0;
      mdata_q <= 16'h0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      mdata_q <= mdata_d;
      err_q   <= err_d;
    end
  end

  // Memory write on the edge leaving ACCESS. A reset during the
  // transaction forces state_q to IDLE, so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (state_q == S_ACCESS && wr_q) mem[addr_q] <= wdata_q;
  end

  // Next-state logic: accept in IDLE/DONE, count down WAIT, one-cycle ACCESS.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    mdata_d = mdata_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (req && (MC == 2'b01 || MC == 2'b10)) begin
          addr_d  = addr;
          wdata_d = WRdata;
          wr_d    = MC[0];
          cnt_d   = CNT_INIT;
          state_d = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
        end else if (req && MC == 2'b11) begin
          err_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ACCESS: begin
        state_d = S_DONE;
        if (!wr_q) mdata_d = mem[addr_q];
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy  = (state_q == S_WAIT) || (state_q == S_ACCESS);
  assign done  = (state_q == S_DONE);
  assign err   = err_q;
  assign Mdata = mdata_q;

endmodule
